// File: rtl/gpio_input_ip.sv
// GPIO input peripheral: synchronizes external pins, exposes their level,
// captures enabled rising/falling edges into sticky W1C status bits and
// raises a level interrupt for unmasked status bits.
module gpio_input_ip #(
    parameter int unsigned WIDTH       = 32,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [31:0]      addr,
    input  logic [31:0]      write_data,
    output logic [31:0]      read_data,
    input  logic             write_enable,
    input  logic             read_enable,
    input  logic             chip_select,
    input  logic [WIDTH-1:0] gpio_in,
    output logic             irq
);

    localparam int unsigned PrimeMax = SYNC_STAGES + 1;
    localparam int unsigned CntW     = $clog2(PrimeMax + 1);

    localparam logic [2:0] IdxData    = 3'd0;
    localparam logic [2:0] IdxRiseEn  = 3'd1;
    localparam logic [2:0] IdxFallEn  = 3'd2;
    localparam logic [2:0] IdxIrqMask = 3'd3;
    localparam logic [2:0] IdxStatus  = 3'd4;

    logic [WIDTH-1:0] stage_q [SYNC_STAGES];
    logic [WIDTH-1:0] stage_d [SYNC_STAGES];
    logic [WIDTH-1:0] prev_q, prev_d;
    logic [WIDTH-1:0] rise_en_q, rise_en_d;
    logic [WIDTH-1:0] fall_en_q, fall_en_d;
    logic [WIDTH-1:0] irq_mask_q, irq_mask_d;
    logic [WIDTH-1:0] status_q, status_d;
    logic [CntW-1:0]  prime_cnt_q, prime_cnt_d;

    logic [WIDTH-1:0] sync_q;
    logic [WIDTH-1:0] rise, fall;
    logic [WIDTH-1:0] set_bits, clr_bits;
    logic [2:0]       idx;
    logic             wr, rd, primed;

    // Only addr[4:2] is decoded; the remaining address bits are don't-care.
    logic unused_addr;
    assign unused_addr = ^{addr[31:5], addr[1:0]};

    assign idx    = addr[4:2];
    assign wr     = chip_select && write_enable;
    assign rd     = chip_select && read_enable;
    assign sync_q = stage_q[SYNC_STAGES-1];
    assign primed = (prime_cnt_q == CntW'(PrimeMax));
    assign rise   = sync_q & ~prev_q;
    assign fall   = ~sync_q & prev_q;

    // Next-state for synchronizer, edge history, config and status registers.
    always_comb begin
        stage_d[0] = gpio_in;
        for (int unsigned i = 1; i < SYNC_STAGES; i++) begin
            stage_d[i] = stage_q[i-1];
        end
        prev_d = sync_q;

        rise_en_d  = rise_en_q;
        fall_en_d  = fall_en_q;
        irq_mask_d = irq_mask_q;
        clr_bits   = '0;
        if (wr) begin
            case (idx)
                IdxRiseEn:  rise_en_d  = write_data[WIDTH-1:0];
                IdxFallEn:  fall_en_d  = write_data[WIDTH-1:0];
                IdxIrqMask: irq_mask_d = write_data[WIDTH-1:0];
                IdxStatus:  clr_bits   = write_data[WIDTH-1:0];
                default:    ;
            endcase
        end

        // Edges seen before the synchronizer has flushed post-reset are bogus.
        set_bits = primed ? ((rise & rise_en_q) | (fall & fall_en_q)) : '0;
        // Set has priority over a same-cycle clear.
        status_d = (status_q & ~clr_bits) | set_bits;

        prime_cnt_d = primed ? prime_cnt_q : prime_cnt_q + CntW'(1);
    end

    // State registers with synchronous reset; reset discards any bus write.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < SYNC_STAGES; i++) begin
                stage_q[i] <= '0;
            end
            prev_q      <= '0;
            rise_en_q   <= '0;
            fall_en_q   <= '0;
            irq_mask_q  <= '0;
            status_q    <= '0;
            prime_cnt_q <= '0;
        end else begin
            for (int unsigned i = 0; i < SYNC_STAGES; i++) begin
                stage_q[i] <= stage_d[i];
            end
            prev_q      <= prev_d;
            rise_en_q   <= rise_en_d;
            fall_en_q   <= fall_en_d;
            irq_mask_q  <= irq_mask_d;
            status_q    <= status_d;
            prime_cnt_q <= prime_cnt_d;
        end
    end

    // Combinational read mux, zero outside a qualified read.
    always_comb begin
        read_data = 32'h0;
        if (rd) begin
            case (idx)
                IdxData:    read_data = 32'(sync_q);
                IdxRiseEn:  read_data = 32'(rise_en_q);
                IdxFallEn:  read_data = 32'(fall_en_q);
                IdxIrqMask: read_data = 32'(irq_mask_q);
                IdxStatus:  read_data = 32'(status_q);
                default:    read_data = 32'h0;
            endcase
        end
    end

    assign irq = |(status_q & irq_mask_q);

endmodule

// File: doc/gpio_input_ip.md
Name: gpio_input_ip

Overview:
- Memory-mapped GPIO input peripheral; the input-direction counterpart to the GPIO output block, on the same simple chip-select bus.
- Samples external pins through a synchronizer and exposes their level to software.
- Detects per-bit rising/falling edges into sticky write-1-to-clear status flags.
- Drives one level interrupt line to the system interrupt input.

Parameters:
- WIDTH, 32, number of input pins (1..32); registers are zero-extended to 32 bits on read.
- SYNC_STAGES, 2, synchronizer flop depth (2..4).

Ports:
- clk  input  1  system clock, all logic on rising edge
- rst  input  1  synchronous, active-high reset
- addr  input  32  byte address; only addr[4:2] decoded, all other bits ignored
- write_data  input  32  write data; bits [WIDTH-1:0] used
- read_data  output  32  combinational read data
- write_enable  input  1  write strobe, qualified by chip_select
- read_enable  input  1  read strobe, qualified by chip_select
- chip_select  input  1  block select from the address decoder
- gpio_in  input  WIDTH  asynchronous external pins
- irq  output  1  level interrupt, high while any unmasked status bit is set

Behaviour:
- One clock (clk); reset is synchronous and active-high (rst), sampled on the rising edge of clk.
- Register map, word index addr[4:2]:
  - 0 DATA: read-only, synchronized pin level.
  - 1 RISE_EN: read/write.
  - 2 FALL_EN: read/write.
  - 3 IRQ_MASK: read/write, 1 = enabled.
  - 4 STATUS: read, write-1-to-clear.
  - 5..7: unmapped, read 0, writes ignored.
- Reset:
  - Every register, every synchronizer stage, the previous-value register and the prime counter clear to 0.
  - Consequence: read_data = 0 and irq = 0.
- Writes:
  - Take effect on the clk edge where chip_select && write_enable.
  - Writes to DATA are ignored.
  - STATUS write clears the bits where write_data = 1; bits where write_data = 0 are unchanged.
- Reads:
  - read_data = selected register when chip_select && read_enable, else 32'h0.
  - Purely combinational, no side effects; reading STATUS does not clear it.
- Synchronizer and edge detect:
  - gpio_in passes through SYNC_STAGES flops to give sync_q; prev_q <= sync_q every cycle.
  - DATA = sync_q. A pin change is visible in DATA SYNC_STAGES edges after it is set up before an edge.
  - rise = sync_q & ~prev_q; fall = ~sync_q & prev_q.
- STATUS set rule:
  - Set on the next edge: status[i] <= 1 when (rise[i] & RISE_EN[i]) | (fall[i] & FALL_EN[i]).
  - Total latency from pin change to STATUS set is SYNC_STAGES+1 edges.
  - Edges on disabled bits are discarded, not held pending.
- Prime counter:
  - After rst deasserts, a counter runs SYNC_STAGES+1 cycles.
  - While not primed, edge detection is suppressed. A pin held high through reset therefore never produces a spurious rise.
  - The counter saturates at its terminal value; rst mid-operation restarts it.
- Simultaneous events:
  - A set and a W1C on the same bit in the same cycle: set wins, bit stays 1.
  - A W1C on other bits does not affect bits being set.
  - A write to RISE_EN/FALL_EN takes effect for edges detected on the following cycle.
- irq:
  - Combinational: irq = |(STATUS & IRQ_MASK).
  - Falls in the same cycle that STATUS is cleared or the mask bit is cleared.
- Pulse capture: a pulse shorter than one clk period may be missed; at least 2 clk periods high/low is guaranteed to be captured.
- Reset mid-operation: rst asserted in any cycle clears everything on that edge. A simultaneous bus write is discarded.

Test Plan:
- Reset with gpio_in = 32'hFFFF_FFFF held: read all registers -> DATA reads 32'hFFFF_FFFF after 2 cycles; STATUS = 0; irq = 0 indefinitely.
- RISE_EN = 32'h1, IRQ_MASK = 32'h1, then gpio_in[0] 0->1:
  - DATA[0] = 1 two edges after the change; STATUS = 32'h1 three edges after; irq = 1 the same cycle.
  - Write STATUS = 32'h1 -> STATUS = 0, irq = 0 next cycle.
- FALL_EN = 32'h8000_0000, mask = 0, then gpio_in[31] 1->0:
  - STATUS = 32'h8000_0000 with irq = 0.
  - Write IRQ_MASK = 32'h8000_0000 -> irq = 1 next cycle.
- W1C collision: STATUS = 32'h3; in the same cycle bit 0 gets a new rise and the bus writes STATUS = 32'h3 -> STATUS = 32'h1.
- Disabled edge: RISE_EN = 0, toggle gpio_in[5] -> STATUS stays 0. Then write RISE_EN = 32'h20 -> STATUS stays 0, no late capture.
- Bus qualification:
  - Read with chip_select = 0 -> read_data = 0.
  - Write DATA = 32'hDEAD_BEEF -> DATA unchanged.
  - addr = 32'h18 read -> 0.
  - rst during a write -> all registers read 0.
